// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared address map, register offsets and decode helper for the data-port responder
package riscv_mem_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h1000_0000;

    localparam logic [3:0] CONSOLE_DATA_OFS = 4'h0;
    localparam logic [3:0] STATUS_OFS       = 4'h4;
    localparam logic [3:0] MTIME_OFS        = 4'h8;
    localparam logic [3:0] MTIMECMP_OFS     = 4'hC;

    localparam int STAT_TX_VALID = 0;
    localparam int STAT_EMPTY    = 1;
    localparam int STAT_FULL     = 2;
    localparam int STAT_OVF      = 3;

    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_MMIO = 2'd1,
        REG_NONE = 2'd2
    } region_e;

    // RAM wins if a large RAM_WORDS ever overlaps the MMIO page.
    function automatic region_e decode_region(input logic [31:0] addr,
                                              input logic [31:0] ram_bytes,
                                              input logic [27:0] mmio_page);
        if (addr < ram_bytes) begin
            return REG_RAM;
        end else if (addr[31:4] == mmio_page) begin
            return REG_MMIO;
        end else begin
            return REG_NONE;
        end
    endfunction

endpackage

// File: rtl/console_fifo.sv
// rtl/console_fifo.sv - console transmit FIFO; a push into a full FIFO is accepted only if a pop frees a slot
module console_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dmem_mmio_responder.sv
// rtl/dmem_mmio_responder.sv - M-stage data port responder: byte-enabled word RAM plus console/timer MMIO page
module dmem_mmio_responder
    import riscv_mem_pkg::*;
#(
    parameter int          RAM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic        MemWriteM,
    input  logic [3:0]  byteEnable,
    output logic [31:0] RD_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        timer_irq
);

    localparam int          RAM_AW    = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;

    region_e           region;
    logic [3:0]        reg_ofs;
    logic [RAM_AW-1:0] ram_idx;
    logic [31:0]       ram [RAM_WORDS];

    logic              ram_we;
    logic              con_wr;
    logic              stat_wr;
    logic              cmp_wr;

    logic [31:0]       mtime;
    logic [31:0]       mtimecmp;
    logic [31:0]       mtime_next;
    logic [31:0]       mtimecmp_next;
    logic              ovf;
    logic [31:0]       status;

    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [7:0]        fifo_head;

    assign region  = decode_region(ALUResultM, RAM_BYTES, MMIO_BASE[31:4]);
    assign reg_ofs = {ALUResultM[3:2], 2'b00};
    assign ram_idx = ALUResultM[RAM_AW+1:2];

    assign ram_we  = MemWriteM && (region == REG_RAM);
    assign con_wr  = MemWriteM && (region == REG_MMIO) && (reg_ofs == CONSOLE_DATA_OFS) && byteEnable[0];
    assign stat_wr = MemWriteM && (region == REG_MMIO) && (reg_ofs == STATUS_OFS) && byteEnable[0]
                     && WriteDataM[STAT_OVF];
    assign cmp_wr  = MemWriteM && (region == REG_MMIO) && (reg_ofs == MTIMECMP_OFS);

    assign fifo_pop = tx_valid && tx_ready;
    assign tx_valid = (fifo_count != '0);
    assign tx_data  = fifo_head;

    console_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_console_fifo (
        .clk    (clk),
        .resetn (reset),
        .push   (con_wr),
        .pop    (fifo_pop),
        .wdata  (WriteDataM[7:0]),
        .head   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // RAM contents survive reset; the reset term only drops a store issued while reset is held.
    always_ff @(posedge clk or negedge reset) begin
        if (reset && ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEnable[i]) begin
                    ram[ram_idx][8*i +: 8] <= WriteDataM[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        mtime_next    = mtime + 32'd1;
        mtimecmp_next = mtimecmp;
        if (cmp_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEnable[i]) begin
                    mtimecmp_next[8*i +: 8] = WriteDataM[8*i +: 8];
                end
            end
        end
    end

    // The irq flop compares the values being loaded, so it always agrees with the live registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mtime     <= '0;
            mtimecmp  <= '1;
            timer_irq <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            mtime     <= mtime_next;
            mtimecmp  <= mtimecmp_next;
            timer_irq <= (mtime_next >= mtimecmp_next);
            if (con_wr && fifo_full && !fifo_pop) begin
                ovf <= 1'b1;
            end else if (stat_wr) begin
                ovf <= 1'b0;
            end
        end
    end

    always_comb begin
        status                = '0;
        status[STAT_TX_VALID] = tx_valid;
        status[STAT_EMPTY]    = fifo_empty;
        status[STAT_FULL]     = fifo_full;
        status[STAT_OVF]      = ovf;
    end

    always_comb begin
        RD_data = '0;
        case (region)
            REG_RAM: RD_data = ram[ram_idx];
            REG_MMIO: begin
                case (reg_ofs)
                    STATUS_OFS:   RD_data = status;
                    MTIME_OFS:    RD_data = mtime;
                    MTIMECMP_OFS: RD_data = mtimecmp;
                    default:      RD_data = '0;
                endcase
            end
            default: RD_data = '0;
        endcase
    end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// tb/tb_dmem_mmio_responder.sv - directed bench with a queue/array reference model checked every cycle
module tb_dmem_mmio_responder;

    localparam logic [31:0] MMIO  = 32'h1000_0000;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ALUResultM = '0;
    logic [31:0] WriteDataM = '0;
    logic        MemWriteM = 1'b0;
    logic [3:0]  byteEnable = '0;
    logic [31:0] RD_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        timer_irq;

    always #5 clk = ~clk;

    dmem_mmio_responder dut (
        .clk        (clk),
        .reset      (reset),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .MemWriteM  (MemWriteM),
        .byteEnable (byteEnable),
        .RD_data    (RD_data),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .timer_irq  (timer_irq)
    );

    int checks = 0;
    int failures = 0;
    logic check_en = 1'b0;

    logic [31:0] m_ram [int];
    logic [3:0]  m_known [int];
    logic [7:0]  m_q [$];
    logic [31:0] m_mtime, m_cmp;
    logic        m_ovf, m_irq;
    logic        mp_pop, mp_push;
    int          mw;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int region_of(input logic [31:0] a);
        if (a < 32'd4096) return 0;
        if (a >= MMIO && a < MMIO + 32'd16) return 1;
        return 2;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] m);
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = 8'hFF;
        return r;
    endfunction

    // Expected read word and which byte lanes of it are defined.
    task automatic exp_read(input logic [31:0] a, output logic [31:0] d, output logic [3:0] known);
        int w;
        d = '0;
        known = 4'hF;
        if (region_of(a) == 0) begin
            w = int'(a >> 2);
            if (m_ram.exists(w)) begin
                d = m_ram[w];
                known = m_known[w];
            end else begin
                known = 4'h0;
            end
        end else if (region_of(a) == 1) begin
            case (a[3:2])
                2'd1: d = {28'd0, m_ovf, m_q.size() == DEPTH, m_q.size() == 0, m_q.size() != 0};
                2'd2: d = m_mtime;
                2'd3: d = m_cmp;
                default: d = '0;
            endcase
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mtime = '0;
            m_cmp   = '1;
            m_ovf   = 1'b0;
            m_irq   = 1'b0;
            m_q.delete();
        end else begin
            mp_pop  = (m_q.size() != 0) && tx_ready;
            mp_push = 1'b0;
            if (MemWriteM) begin
                if (region_of(ALUResultM) == 0) begin
                    mw = int'(ALUResultM >> 2);
                    if (!m_ram.exists(mw)) begin
                        m_ram[mw] = '0;
                        m_known[mw] = '0;
                    end
                    for (int i = 0; i < 4; i++) begin
                        if (byteEnable[i]) begin
                            m_ram[mw][8*i +: 8] = WriteDataM[8*i +: 8];
                            m_known[mw][i] = 1'b1;
                        end
                    end
                end else if (region_of(ALUResultM) == 1) begin
                    case (ALUResultM[3:2])
                        2'd0: mp_push = byteEnable[0];
                        2'd1: if (byteEnable[0] && WriteDataM[3]) m_ovf = 1'b0;
                        2'd3: for (int i = 0; i < 4; i++)
                                  if (byteEnable[i]) m_cmp[8*i +: 8] = WriteDataM[8*i +: 8];
                        default: ;
                    endcase
                end
            end
            if (mp_pop) void'(m_q.pop_front());
            if (mp_push) begin
                if (m_q.size() < DEPTH) m_q.push_back(WriteDataM[7:0]);
                else m_ovf = 1'b1;
            end
            m_mtime = m_mtime + 32'd1;
            m_irq   = (m_mtime >= m_cmp);
        end
    end

    always @(negedge clk) begin
        logic [31:0] e;
        logic [3:0]  k;
        if (check_en) begin
            exp_read(ALUResultM, e, k);
            if (k != 4'h0) chk("model_rd_data", RD_data & lane_mask(k), e & lane_mask(k));
            chk("model_tx_valid", {31'd0, tx_valid}, {31'd0, m_q.size() != 0});
            chk("model_tx_data", {24'd0, tx_data}, (m_q.size() != 0) ? {24'd0, m_q[0]} : 32'd0);
            chk("model_timer_irq", {31'd0, timer_irq}, {31'd0, m_irq});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        ALUResultM = a;
        WriteDataM = d;
        byteEnable = be;
        MemWriteM  = 1'b1;
        step();
        MemWriteM  = 1'b0;
        byteEnable = 4'h0;
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string name);
        ALUResultM = a;
        @(negedge clk);
        chk(name, RD_data, exp);
        step();
    endtask

    logic [7:0] drain_exp [4];
    int         n;
    logic       seen;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check_en = 1'b1;

        rd_chk(MMIO + 32'h8, 32'h0, "reset_mtime");
        rd_chk(MMIO + 32'hC, 32'hFFFF_FFFF, "reset_mtimecmp");
        rd_chk(MMIO + 32'h4, 32'h2, "reset_status");

        sw(32'h0, 32'h1234_5678, 4'hF);
        sw(32'h10, 32'hDEAD_BEEF, 4'hF);
        sw(32'h10, 32'h0055_0000, 4'b0100);
        rd_chk(32'h10, 32'hDE55_BEEF, "byte_lane_write");
        sw(32'hFFC, 32'hA5A5_0001, 4'hF);
        rd_chk(32'hFFC, 32'hA5A5_0001, "ram_last_word");
        sw(32'h1000, 32'h1111_1111, 4'hF);
        rd_chk(32'h1000, 32'h0, "ram_end_unmapped");
        rd_chk(32'h0, 32'h1234_5678, "ram_end_no_alias");

        for (int i = 0; i < 5; i++) sw(MMIO, 32'h41 + 32'(i), 4'h1);
        rd_chk(MMIO + 32'h4, 32'hD, "overflow_status");
        rd_chk(MMIO, 32'h0, "console_reads_zero");
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drain_order", {24'd0, tx_data}, 32'h41 + 32'(i));
            step();
        end
        @(negedge clk);
        chk("drained_empty", {31'd0, tx_valid}, 32'd0);
        step();
        tx_ready = 1'b0;
        sw(MMIO + 32'h4, 32'h8, 4'b0010);
        rd_chk(MMIO + 32'h4, 32'hA, "ovf_clear_needs_be0");
        sw(MMIO + 32'h4, 32'h8, 4'b0001);
        rd_chk(MMIO + 32'h4, 32'h2, "ovf_cleared");

        for (int i = 0; i < 4; i++) sw(MMIO, 32'h61 + 32'(i), 4'h1);
        rd_chk(MMIO + 32'h4, 32'h5, "full_status");
        tx_ready = 1'b1;
        sw(MMIO, 32'h5A, 4'h1);
        tx_ready = 1'b0;
        rd_chk(MMIO + 32'h4, 32'h5, "push_pop_when_full");
        drain_exp = '{8'h62, 8'h63, 8'h64, 8'h5A};
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("push_pop_drain", {24'd0, tx_data}, {24'd0, drain_exp[i]});
            step();
        end
        tx_ready = 1'b0;

        sw(MMIO + 32'hC, m_mtime + 32'd3, 4'hF);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 10) begin
            @(negedge clk);
            n++;
            seen = timer_irq;
            step();
        end
        chk("irq_latency", 32'(n), 32'd3);
        repeat (3) step();
        @(negedge clk);
        chk("irq_held", {31'd0, timer_irq}, 32'd1);
        step();
        sw(MMIO + 32'hC, 32'hFFFF_FFFF, 4'hF);
        @(negedge clk);
        chk("irq_cleared", {31'd0, timer_irq}, 32'd0);
        step();
        sw(MMIO + 32'hC, 32'h0000_00AB, 4'b0001);
        rd_chk(MMIO + 32'hC, 32'hFFFF_FFAB, "mtimecmp_byte_write");
        sw(MMIO + 32'hC, 32'hFFFF_FFFF, 4'hF);
        sw(MMIO + 32'h8, 32'h0, 4'hF);
        ALUResultM = MMIO + 32'h8;
        step();

        rd_chk(32'h2000_0000, 32'h0, "unmapped_read");
        sw(32'h2000_0000, 32'hFFFF_FFFF, 4'hF);
        rd_chk(32'h0, 32'h1234_5678, "unmapped_write_ram");
        rd_chk(MMIO + 32'hC, 32'hFFFF_FFFF, "unmapped_write_cmp");
        rd_chk(MMIO + 32'h4, 32'h2, "unmapped_write_status");

        sw(MMIO + 32'hC, 32'h0, 4'hF);
        sw(MMIO, 32'h71, 4'h1);
        sw(MMIO, 32'h72, 4'h1);
        ALUResultM = MMIO + 32'h8;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_timer_irq", {31'd0, timer_irq}, 32'd0);
        chk("rst_mtime", RD_data, 32'h0);
        step();
        ALUResultM = MMIO + 32'hC;
        @(negedge clk);
        chk("rst_mtimecmp", RD_data, 32'hFFFF_FFFF);
        step();
        reset = 1'b1;
        rd_chk(32'h10, 32'hDE55_BEEF, "ram_kept_over_reset");
        rd_chk(MMIO + 32'h4, 32'h2, "rst_status");

        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
